dla_pipe_slice: RTL and testbench

//  Parametrised elastic pipeline slice for the DLA requant datapath.

---
 rtl/dla_pipe_slice.sv | 62 ++++++
 tb/tb_dla_pipe_slice.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/dla_pipe_slice.sv
// dla_pipe_slice: elastic valid/ready pipeline slice with bubble collapse and optional input skid buffer
module dla_pipe_slice #(
  parameter int DATA_W = 26,
  parameter int STAGES = 2,
  parameter int SKID = 1,
  parameter int CNT_W = $clog2(STAGES + SKID + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  occupancy
);
  logic [STAGES-1:0] v, ld, vin;
  logic [DATA_W-1:0] d [STAGES];
  logic [DATA_W-1:0] dsrc [STAGES];
  logic [DATA_W-1:0] skid_d;
  logic skid_v, skid_next, rdy, in_fire, full;
  always_comb begin
    full = 1'b1;
    for (int k = STAGES - 1; k >= 0; k--) begin
      full = full & v[k];
      ld[k] = out_ready | !full;
    end
    in_ready = SKID != 0 ? rdy : rdy & ld[0];
    in_fire = in_valid & in_ready;
    skid_next = SKID != 0 && !flush && !ld[0] && (skid_v || in_fire);
    vin = (v << 1) | STAGES'(skid_v | in_fire);
    dsrc[0] = skid_v ? skid_d : in_data;
    for (int k = 1; k < STAGES; k++) dsrc[k] = d[k-1];
    occupancy = CNT_W'(skid_v);
    for (int k = 0; k < STAGES; k++) occupancy = occupancy + CNT_W'(v[k]);
  end
  // rdy stays low through reset so nothing is accepted until the first clean edge
  always_ff @(posedge clk) begin
    if (rst) begin
      v <= '0;
      skid_v <= 1'b0;
      skid_d <= '0;
      rdy <= 1'b0;
      for (int k = 0; k < STAGES; k++) d[k] <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (ld[k]) begin
          v[k] <= vin[k];
          if (vin[k]) d[k] <= dsrc[k];
        end
      end
      if (flush) v <= '0;
      skid_v <= skid_next;
      if (in_fire && !ld[0]) skid_d <= in_data;
      rdy <= SKID != 0 ? !skid_next : 1'b1;
    end
  end
  assign out_valid = v[STAGES-1];
  assign out_data = d[STAGES-1];
endmodule

// File: tb/tb_dla_pipe_slice.sv
// tb_dla_pipe_slice: directed vector table on the default slice plus randomized scoreboard on two variants
module tb_dla_pipe_slice;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        fl0, iv0, ir0, ov0, or0;
  logic [25:0] id0, od0;
  logic [1:0]  oc0;

  logic       rfl, rv, ror;
  logic [7:0] rd;
  logic       r_ir [2];
  logic       r_ov [2];
  logic [7:0] r_od [2];
  logic [1:0] oc1;
  logic [2:0] oc2;

  dla_pipe_slice u0 (.clk(clk), .rst(rst), .flush(fl0), .in_valid(iv0), .in_ready(ir0), .in_data(id0),
    .out_valid(ov0), .out_ready(or0), .out_data(od0), .occupancy(oc0));
  dla_pipe_slice #(.DATA_W(8), .STAGES(1), .SKID(1)) u1 (.clk(clk), .rst(rst), .flush(rfl), .in_valid(rv),
    .in_ready(r_ir[0]), .in_data(rd), .out_valid(r_ov[0]), .out_ready(ror), .out_data(r_od[0]), .occupancy(oc1));
  dla_pipe_slice #(.DATA_W(8), .STAGES(4), .SKID(0)) u2 (.clk(clk), .rst(rst), .flush(rfl), .in_valid(rv),
    .in_ready(r_ir[1]), .in_data(rd), .out_valid(r_ov[1]), .out_ready(ror), .out_data(r_od[1]), .occupancy(oc2));

  typedef struct {
    logic iv; logic [25:0] id; logic ordy; logic fl;
    logic ov; logic [25:0] od; logic [1:0] occ; logic ir;
  } vec_t;
  vec_t tv [26];

  int passed = 0, total = 0;

  function automatic vec_t mk(logic iv, logic [25:0] id, logic o, logic f,
                              logic ev, logic [25:0] ed, logic [1:0] eo, logic ei);
    vec_t r;
    r.iv = iv; r.id = id; r.ordy = o; r.fl = f; r.ov = ev; r.od = ed; r.occ = eo; r.ir = ei;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  logic [7:0] q [2][$];
  logic       pov [2];
  logic [7:0] pod [2];
  logic       infire [2];
  logic       ofire [2];
  logic       por, pfl;
  int         occ;

  initial begin
    tv[0]  = mk(0, 0, 0, 0, 0, 0, 0, 1);
    tv[1]  = mk(1, 'h1, 1, 0, 0, 0, 1, 1);
    tv[2]  = mk(1, 'h2, 1, 0, 1, 'h1, 2, 1);
    tv[3]  = mk(1, 'h3, 1, 0, 1, 'h2, 2, 1);
    tv[4]  = mk(1, 'h4, 1, 0, 1, 'h3, 2, 1);
    tv[5]  = mk(0, 0, 1, 0, 1, 'h4, 1, 1);
    tv[6]  = mk(0, 0, 1, 0, 0, 0, 0, 1);
    tv[7]  = mk(1, 'h11, 0, 0, 0, 0, 1, 1);
    tv[8]  = mk(1, 'h12, 0, 0, 1, 'h11, 2, 1);
    tv[9]  = mk(1, 'h13, 0, 0, 1, 'h11, 3, 0);
    tv[10] = mk(1, 'h14, 0, 0, 1, 'h11, 3, 0);
    tv[11] = mk(0, 0, 1, 0, 1, 'h12, 2, 1);
    tv[12] = mk(0, 0, 1, 0, 1, 'h13, 1, 1);
    tv[13] = mk(0, 0, 1, 0, 0, 0, 0, 1);
    tv[14] = mk(1, 'h21, 0, 0, 0, 0, 1, 1);
    tv[15] = mk(0, 0, 0, 0, 1, 'h21, 1, 1);
    tv[16] = mk(1, 'h22, 0, 0, 1, 'h21, 2, 1);
    tv[17] = mk(0, 0, 1, 0, 1, 'h22, 1, 1);
    tv[18] = mk(0, 0, 1, 0, 0, 0, 0, 1);
    tv[19] = mk(1, 'h31, 0, 0, 0, 0, 1, 1);
    tv[20] = mk(1, 'h32, 0, 0, 1, 'h31, 2, 1);
    tv[21] = mk(1, 'h33, 0, 1, 0, 0, 0, 1);
    tv[22] = mk(0, 0, 1, 0, 0, 0, 0, 1);
    tv[23] = mk(1, 'h34, 1, 0, 0, 0, 1, 1);
    tv[24] = mk(0, 0, 1, 0, 1, 'h34, 1, 1);
    tv[25] = mk(0, 0, 1, 0, 0, 0, 0, 1);

    rst = 1; fl0 = 0; iv0 = 0; id0 = 0; or0 = 0;
    rfl = 0; rv = 0; ror = 0; rd = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset out_valid", ov0, 0);
    chk("reset out_data", od0, 0);
    chk("reset occupancy", oc0, 0);
    chk("reset in_ready", ir0, 0);
    rst = 0;

    for (int k = 0; k < 26; k++) begin
      iv0 = tv[k].iv; id0 = tv[k].id; or0 = tv[k].ordy; fl0 = tv[k].fl;
      @(posedge clk);
      #1;
      chk($sformatf("row%0d out_valid", k), ov0, tv[k].ov);
      chk($sformatf("row%0d occupancy", k), oc0, tv[k].occ);
      chk($sformatf("row%0d in_ready", k), ir0, tv[k].ir);
      if (tv[k].ov) chk($sformatf("row%0d out_data", k), od0, tv[k].od);
    end

    iv0 = 1; id0 = 'h41; or0 = 0; fl0 = 0;
    @(posedge clk); #1;
    id0 = 'h42;
    @(posedge clk); #1;
    chk("pre-reset occupancy", oc0, 2);
    iv0 = 0; rst = 1;
    @(posedge clk); #1;
    chk("midrst out_valid", ov0, 0);
    chk("midrst out_data", od0, 0);
    chk("midrst occupancy", oc0, 0);
    chk("midrst in_ready", ir0, 0);
    rst = 0;
    @(posedge clk); #1;
    chk("postrst in_ready", ir0, 1);
    chk("postrst out_valid", ov0, 0);

    pov[0] = 0; pov[1] = 0; pod[0] = 0; pod[1] = 0; por = 1; pfl = 0;
    for (int c = 0; c < 10000; c++) begin
      rv = $urandom_range(0, 3) != 0;
      rd = 8'($urandom);
      ror = $urandom_range(0, 3) != 0;
      rfl = $urandom_range(0, 63) == 0;
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        occ = i == 0 ? int'(oc1) : int'(oc2);
        chk($sformatf("rnd%0d occupancy", i), occ, q[i].size());
        chk($sformatf("rnd%0d in_ready", i), r_ir[i],
            i == 0 ? (q[i].size() != 2) : (q[i].size() < 4 || ror));
        if (r_ov[i]) begin
          chk($sformatf("rnd%0d valid_nonempty", i), q[i].size() != 0, 1);
          if (q[i].size() != 0) chk($sformatf("rnd%0d out_data", i), r_od[i], q[i][0]);
        end
        if (pov[i] && !por && !pfl) begin
          chk($sformatf("rnd%0d hold_valid", i), r_ov[i], 1);
          chk($sformatf("rnd%0d hold_data", i), r_od[i], pod[i]);
        end
        infire[i] = rv & r_ir[i];
        ofire[i] = r_ov[i] & ror;
        pov[i] = r_ov[i];
        pod[i] = r_od[i];
      end
      por = ror; pfl = rfl;
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
        if (rfl) q[i].delete();
        else begin
          if (ofire[i] && q[i].size() != 0) void'(q[i].pop_front());
          if (infire[i]) q[i].push_back(rd);
        end
      end
      #1;
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
